fetch_prefetch_queue: RTL and testbench
=======================================

// Module: fetch_prefetch_queue
// PURPOSE
//  Front-end prefetch queue sitting directly upstream of the icache controller.
//  - Sends line-aligned fetch requests to the icache (read_valid/read_ready).
//  - Accepts returned 16-byte lines (dp_valid/dp_ready).
//  - Buffers them in a 2-line circular byte queue.
//  - Presents a 16-byte window at the current EIP to the variable-length x86 decoder.
//  - Handles branch/redirect flush, including discarding an in-flight line.
// PARAMETERS
//  LINE_BYTES  16            bytes per icache line; fixed, window width = LINE_BYTES*8
//  RESET_EIP   32'hFFFF_FFF0 fetch/decode EIP loaded on reset
// PORTS
//  clk           in   1    clock; all state updates on rising edge
//  reset         in   1    synchronous, active-high
//  redirect      in   1    flush queue and restart fetch at redirect_eip
//  redirect_eip  in   32   new EIP, sampled when redirect=1
//  ic_read_valid out  1    fetch request valid to icache controller
//  ic_read_ready in   1    icache accepts request; handshake = valid & ready
//  ic_addr       out  32   request address, {fetch_addr[31:4],4'b0}
//  ic_dp_valid   in   1    returned line valid
//  ic_dp_ready   out  1    queue accepts returned line
//  ic_data       in   128  returned line, byte 0 in [7:0]
//  dec_valid     out  1    at least one byte available (dec_count != 0)
//  dec_eip       out  32   linear EIP of dec_bytes byte 0
//  dec_bytes     out  128  queue bytes rd_ptr..rd_ptr+15 (mod 32); bytes >= dec_count forced 0
//  dec_count     out  5    valid bytes in window, 0..16 (min(count,16))
//  dec_take      in   5    bytes consumed this cycle; honoured only if dec_valid & !redirect
//  perf_stall    out  32   decoder-starved cycle counter (see CONFIGURATION)
// BEHAVIOUR
//  Storage: 32-byte circular queue; rd_ptr[4:0]; count[5:0] (0..32); fetch_addr[31:0].
//  Reset: state=IDLE, count=0, rd_ptr=0, fetch_addr=dec_eip=RESET_EIP, first_line=1.
//   - All outputs 0 except ic_addr={RESET_EIP[31:4],4'b0} and dec_eip=RESET_EIP.
//  FSM (one outstanding request max):
//   IDLE: ic_read_valid=0, ic_dp_ready=0
//     - ->REQ when free space (32-count) >= 16 and no redirect.
//   REQ:  ic_read_valid=1; hold until ic_read_ready.
//     - On handshake ->WAIT.
//   WAIT: ic_dp_ready=1. On ic_dp_valid:
//     - Write line into the half at tail.
//     - Add 16-fetch_addr[3:0] bytes if first_line, else 16; first_line=0.
//     - Bytes below fetch_addr[3:0] are discarded (read pointer skips them).
//     - fetch_addr=(fetch_addr&~15)+16 (mod 2^32). ->IDLE.
//   DROP: ic_dp_ready=1. On ic_dp_valid: discard data, ->IDLE.
//  Redirect (highest priority after reset):
//   - Next cycle: count=0, rd_ptr=redirect_eip[3:0], dec_eip=fetch_addr=redirect_eip, first_line=1.
//   - State: REQ with ic_read_ready in same cycle -> DROP; REQ without -> IDLE (request withdrawn).
//   - WAIT without ic_dp_valid -> DROP; WAIT with ic_dp_valid -> IDLE (line discarded).
//   - DROP stays DROP; IDLE stays IDLE.
//   - dec_take ignored in redirect cycle.
//  Consume: rd_ptr+=dec_take (mod 32); dec_eip+=dec_take (mod 2^32); count-=dec_take.
//   - dec_take > dec_count is illegal; RTL clamps to dec_count.
//  Simultaneous line fill and consume: count_next = count + fill - take; exact, no bubble.
//  Latency:
//   - Request issued the cycle after space is available.
//   - Filled bytes are visible on dec_* the cycle after the dp handshake.
//  Full: count > 16 blocks new requests (IDLE holds). Empty: dec_valid=0, dec_count=0.
//  Wrap-around:
//   - Queue window wraps across byte 31->0.
//   - fetch_addr/dec_eip wrap at 2^32 (FFFF_FFF0 + 16 -> 0000_0000).
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined:
//   - perf_stall increments each cycle with !reset & !dec_valid; saturates at FFFF_FFFF.
//   - Cleared by reset only.
//  Not defined: perf_stall tied to 0; no counter flops.
// TESTING
//  1 Reset, icache ready immediately, line returns 2 cycles later:
//    - ic_addr=FFFF_FFF0 -> dec_valid=1, dec_count=16, dec_eip=FFFF_FFF0.
//    - Next request ic_addr=0000_0000.
//  2 Redirect to 0000_1005 with queue empty, return line:
//    - dec_count=11, dec_bytes[7:0]=line byte 5, dec_eip=0000_1005.
//  3 Redirect while in WAIT, stale line returns 3 cycles later:
//    - Stale line dropped (dec_valid stays 0).
//    - Next ic_addr = redirect line.
//  4 Fill 2 lines, no consume:
//    - count=32, ic_read_valid stays 0.
//    - dec_take=16 -> request issued the following cycle.
//  5 dec_take=7 from rd_ptr=28 while a line fills the same cycle:
//    - rd_ptr=3, count=count+16-7.
//    - Window spans the byte 31->0 boundary correctly.
//  6 With FETCH_PERF_CNT_EN, 10 starved cycles after reset:
//    - perf_stall=10.
//    - Without the macro perf_stall=0.

Source files
------------

// File: rtl/fetch_prefetch_queue_if.sv
// Signal bundle between the prefetch queue (master), the icache controller and the decoder.
// The master modport is the queue side; the slave modport is its environment.
interface fetch_prefetch_queue_if;
    logic         redirect;
    logic [31:0]  redirect_eip;

    logic         ic_read_valid;
    logic         ic_read_ready;
    logic [31:0]  ic_addr;
    logic         ic_dp_valid;
    logic         ic_dp_ready;
    logic [127:0] ic_data;

    logic         dec_valid;
    logic [31:0]  dec_eip;
    logic [127:0] dec_bytes;
    logic [4:0]   dec_count;
    logic [4:0]   dec_take;

    logic [31:0]  perf_stall;

    modport master (
        input  redirect, redirect_eip, ic_read_ready, ic_dp_valid, ic_data, dec_take,
        output ic_read_valid, ic_addr, ic_dp_ready,
        output dec_valid, dec_eip, dec_bytes, dec_count, perf_stall
    );

    modport slave (
        output redirect, redirect_eip, ic_read_ready, ic_dp_valid, ic_data, dec_take,
        input  ic_read_valid, ic_addr, ic_dp_ready,
        input  dec_valid, dec_eip, dec_bytes, dec_count, perf_stall
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Two-line circular byte queue between the icache and the x86 decoder, with redirect flush.
// Define FETCH_PERF_CNT_EN to build the decoder-starvation counter behind perf_stall.
module fetch_prefetch_queue #(
    parameter int unsigned LINE_BYTES = 16,
    parameter logic [31:0] RESET_EIP  = 32'hFFFF_FFF0
) (
    input logic                    clk,
    input logic                    reset,
    fetch_prefetch_queue_if.master bus
);
    localparam int unsigned QBytes = 2 * LINE_BYTES;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDrop} state_e;

    state_e      state_q;
    logic        read_valid_q;
    logic        dp_ready_q;
    logic [4:0]  rd_ptr_q;
    logic [5:0]  count_q;
    logic [31:0] fetch_addr_q;
    logic [31:0] dec_eip_q;
    logic        first_line_q;
    logic [7:0]  mem_q [QBytes];

    logic         dec_valid_w;
    logic [4:0]   dec_count_w;
    logic [4:0]   take_w;
    logic         fill_w;
    logic [5:0]   fill_amt_w;
    logic         tail_half_w;
    logic [127:0] dec_bytes_w;

    assign dec_valid_w = (count_q != 6'd0);
    assign dec_count_w = (count_q > 6'd16) ? 5'd16 : count_q[4:0];

    // Over-long takes are clamped so the queue can never underflow.
    assign take_w = (dec_valid_w && !bus.redirect)
                    ? ((bus.dec_take > dec_count_w) ? dec_count_w : bus.dec_take)
                    : 5'd0;

    assign fill_w     = (state_q == StWait) && bus.ic_dp_valid && !bus.redirect;
    assign fill_amt_w = first_line_q ? (6'd16 - {2'b00, fetch_addr_q[3:0]}) : 6'd16;

    // Half holding byte rd_ptr + count, i.e. where the next line lands.
    assign tail_half_w = rd_ptr_q[4] ^ count_q[4]
                         ^ ((5'(rd_ptr_q[3:0]) + 5'(count_q[3:0])) > 5'd15);

    always_comb begin
        dec_bytes_w = '0;
        for (int i = 0; i < LINE_BYTES; i++) begin
            if (5'(i) < dec_count_w) begin
                dec_bytes_w[i*8 +: 8] = mem_q[rd_ptr_q + 5'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_w) begin
            for (int i = 0; i < LINE_BYTES; i++) begin
                mem_q[{tail_half_w, 4'(i)}] <= bus.ic_data[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q     <= {1'b0, RESET_EIP[3:0]};
            count_q      <= 6'd0;
            fetch_addr_q <= RESET_EIP;
            dec_eip_q    <= RESET_EIP;
            first_line_q <= 1'b1;
        end else if (bus.redirect) begin
            rd_ptr_q     <= {1'b0, bus.redirect_eip[3:0]};
            count_q      <= 6'd0;
            fetch_addr_q <= bus.redirect_eip;
            dec_eip_q    <= bus.redirect_eip;
            first_line_q <= 1'b1;
        end else begin
            rd_ptr_q  <= rd_ptr_q + take_w;
            count_q   <= count_q + (fill_w ? fill_amt_w : 6'd0) - {1'b0, take_w};
            dec_eip_q <= dec_eip_q + {27'd0, take_w};
            if (fill_w) begin
                fetch_addr_q <= {fetch_addr_q[31:4] + 28'd1, 4'b0000};
                first_line_q <= 1'b0;
            end
        end
    end

    // Request FSM; handshake outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            read_valid_q <= 1'b0;
            dp_ready_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!bus.redirect && (count_q <= 6'd16)) begin
                        state_q      <= StReq;
                        read_valid_q <= 1'b1;
                    end
                end
                StReq: begin
                    if (bus.ic_read_ready) begin
                        state_q      <= bus.redirect ? StDrop : StWait;
                        read_valid_q <= 1'b0;
                        dp_ready_q   <= 1'b1;
                    end else if (bus.redirect) begin
                        state_q      <= StIdle;
                        read_valid_q <= 1'b0;
                    end
                end
                StWait: begin
                    if (bus.ic_dp_valid) begin
                        state_q    <= StIdle;
                        dp_ready_q <= 1'b0;
                    end else if (bus.redirect) begin
                        state_q <= StDrop;
                    end
                end
                StDrop: begin
                    // The owed line is gone once it arrives, redirect or not.
                    if (bus.ic_dp_valid) begin
                        state_q    <= StIdle;
                        dp_ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= StIdle;
                    read_valid_q <= 1'b0;
                    dp_ready_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= 32'd0;
        end else if (!dec_valid_w && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign bus.perf_stall = perf_q;
`else
    assign bus.perf_stall = 32'd0;
`endif

    assign bus.ic_read_valid = read_valid_q;
    assign bus.ic_dp_ready   = dp_ready_q;
    assign bus.ic_addr       = {fetch_addr_q[31:4], 4'b0000};
    assign bus.dec_valid     = dec_valid_w;
    assign bus.dec_count     = dec_count_w;
    assign bus.dec_eip       = dec_eip_q;
    assign bus.dec_bytes     = dec_bytes_w;
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: directed scenarios plus random traffic, checked every
// cycle against an address-level model of the queue contents and request protocol.
module tb_fetch_prefetch_queue;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_prefetch_queue_if bus ();

    fetch_prefetch_queue dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: decoder window is just (eip, count); bytes are a function of address.
    int          m_count;
    logic [31:0] m_eip;
    logic [31:0] m_fetch;
    bit          m_first;
    bit          m_req;
    bit          m_owe;
    bit          m_stale;
    longint      m_perf;

    // Icache responder.
    logic [31:0] resp_q [$];
    int          resp_wait;
    int          resp_delay;
    bit          resp_hold;

    function automatic logic [7:0] bf(input logic [31:0] a);
        return (a[7:0] * 8'd37) ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        int dc;
        logic [127:0] eb;
        logic [31:0] ep;
        dc = (m_count > 16) ? 16 : m_count;
        eb = '0;
        for (int i = 0; i < dc; i++) eb[i*8 +: 8] = bf(m_eip + 32'(i));
`ifdef FETCH_PERF_CNT_EN
        ep = 32'(m_perf);
`else
        ep = 32'd0;
`endif
        chk("ic_read_valid", 128'(bus.ic_read_valid), 128'(m_req));
        chk("ic_dp_ready", 128'(bus.ic_dp_ready), 128'(m_owe || m_stale));
        chk("ic_addr", 128'(bus.ic_addr), 128'({m_fetch[31:4], 4'h0}));
        chk("dec_valid", 128'(bus.dec_valid), 128'(m_count != 0));
        chk("dec_count", 128'(bus.dec_count), 128'(dc));
        chk("dec_eip", 128'(bus.dec_eip), 128'(m_eip));
        chk("dec_bytes", bus.dec_bytes, eb);
        chk("perf_stall", 128'(bus.perf_stall), 128'(ep));
    endtask

    task automatic model_step(input bit dv);
        bit idle, rr, n_req, n_owe, n_stale;
        int dc, tk, fill;
        idle = !m_req && !m_owe && !m_stale;
        rr = bus.ic_read_ready;
        if (reset) begin
            m_count = 0; m_eip = 32'hFFFF_FFF0; m_fetch = 32'hFFFF_FFF0; m_first = 1;
            m_req = 0; m_owe = 0; m_stale = 0; m_perf = 0;
        end else begin
            if (m_count == 0 && m_perf < 64'hFFFF_FFFF) m_perf++;
            if (bus.redirect) begin
                m_stale = (m_req && rr) || ((m_owe || m_stale) && !dv);
                m_req = 0; m_owe = 0;
                m_count = 0; m_eip = bus.redirect_eip; m_fetch = bus.redirect_eip; m_first = 1;
            end else begin
                dc = (m_count > 16) ? 16 : m_count;
                tk = int'(bus.dec_take);
                if (tk > dc) tk = dc;
                fill = 0;
                if (m_owe && dv) fill = m_first ? 16 - int'(m_fetch[3:0]) : 16;
                n_req = idle ? (m_count <= 16) : (m_req && !rr);
                n_owe = (m_req && rr) || (m_owe && !dv);
                n_stale = m_stale && !dv;
                m_count = m_count + fill - tk;
                m_eip = m_eip + 32'(tk);
                if (m_owe && dv) begin
                    m_fetch = {m_fetch[31:4], 4'h0} + 32'd16;
                    m_first = 0;
                end
                m_req = n_req; m_owe = n_owe; m_stale = n_stale;
            end
        end
    endtask

    task automatic tick();
        bit dv, hs_req, hs_dp;
        logic [127:0] dd;
        logic [31:0] req_addr;
        dv = !resp_hold && resp_q.size() != 0 && resp_wait == 0;
        dd = '0;
        if (dv) for (int j = 0; j < 16; j++) dd[j*8 +: 8] = bf(resp_q[0] + 32'(j));
        bus.ic_dp_valid = dv;
        bus.ic_data = dd;
        hs_req = (bus.ic_read_valid === 1'b1) && bus.ic_read_ready;
        hs_dp = dv && (bus.ic_dp_ready === 1'b1);
        req_addr = bus.ic_addr;
        @(posedge clk);
        model_step(dv);
        if (reset) begin
            resp_q.delete();
            resp_wait = 0;
        end else begin
            if (resp_wait > 0) resp_wait--;
            if (hs_dp && resp_q.size() != 0) void'(resp_q.pop_front());
            if (hs_req) begin
                resp_q.push_back(req_addr);
                resp_wait = resp_delay;
            end
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_valid(input string name, input int bound);
        int n = 0;
        while (!bus.dec_valid && n < bound) begin
            tick();
            n++;
        end
        chk(name, 128'(bus.dec_valid), 128'(1));
    endtask

    initial begin
        reset = 1; bus.redirect = 0; bus.redirect_eip = 0; bus.ic_read_ready = 0;
        bus.dec_take = 0; bus.ic_dp_valid = 0; bus.ic_data = '0;
        resp_delay = 1; resp_hold = 0; resp_wait = 0;
        m_count = 0; m_eip = 0; m_fetch = 0; m_first = 1;
        m_req = 0; m_owe = 0; m_stale = 0; m_perf = 0;
        tick(); tick();
        chk("rst_ic_addr", 128'(bus.ic_addr), 128'(32'hFFFF_FFF0));
        chk("rst_dec_eip", 128'(bus.dec_eip), 128'(32'hFFFF_FFF0));
        chk("rst_dec_valid", 128'(bus.dec_valid), 128'(0));
        chk("rst_read_valid", 128'(bus.ic_read_valid), 128'(0));
        chk("rst_dec_count", 128'(bus.dec_count), 128'(0));

        // Ten starved cycles with the icache refusing requests.
        reset = 0;
        repeat (10) tick();
`ifdef FETCH_PERF_CNT_EN
        chk("perf_ten", 128'(bus.perf_stall), 128'(10));
`else
        chk("perf_off", 128'(bus.perf_stall), 128'(0));
`endif

        // First line at the reset vector, then the fetch address wraps to zero.
        bus.ic_read_ready = 1;
        wait_valid("first_line_timeout", 20);
        chk("first_count", 128'(bus.dec_count), 128'(16));
        chk("first_eip", 128'(bus.dec_eip), 128'(32'hFFFF_FFF0));
        chk("next_addr_wrap", 128'(bus.ic_addr), 128'(32'h0000_0000));

        // Two lines resident: no further requests until space frees up.
        repeat (12) tick();
        chk("full_no_req", 128'(bus.ic_read_valid), 128'(0));
        chk("full_byte0", 128'(bus.dec_bytes[7:0]), 128'(bf(32'hFFFF_FFF0)));
        bus.dec_take = 16;
        tick();
        bus.dec_take = 0;
        bus.ic_read_ready = 0;
        tick();
        chk("req_after_take", 128'(bus.ic_read_valid), 128'(1));
        chk("eip_wrapped", 128'(bus.dec_eip), 128'(32'h0000_0000));

        // Read pointer at 28; a line fills while the decoder consumes.
        bus.ic_read_ready = 1;
        resp_hold = 1;
        bus.dec_take = 12;
        tick();
        bus.dec_take = 0;
        repeat (3) tick();
        chk("ptr28_count", 128'(bus.dec_count), 128'(4));
        chk("ptr28_eip", 128'(bus.dec_eip), 128'(32'h0000_000C));
        resp_hold = 0;
        bus.dec_take = 3;
        tick();
        chk("fill_take_count", 128'(bus.dec_count), 128'(16));
        chk("fill_take_eip", 128'(bus.dec_eip), 128'(32'h0000_000F));
        chk("span_byte0", 128'(bus.dec_bytes[7:0]), 128'(bf(32'h0000_000F)));
        chk("span_byte1", 128'(bus.dec_bytes[15:8]), 128'(bf(32'h0000_0010)));
        bus.dec_take = 7;
        tick();
        bus.dec_take = 0;
        chk("take7_count", 128'(bus.dec_count), 128'(10));
        chk("take7_eip", 128'(bus.dec_eip), 128'(32'h0000_0016));

        // Redirect to an unaligned EIP.
        bus.redirect = 1;
        bus.redirect_eip = 32'h0000_1005;
        tick();
        bus.redirect = 0;
        chk("redirect_flush", 128'(bus.dec_valid), 128'(0));
        wait_valid("redirect_timeout", 30);
        chk("redir_count", 128'(bus.dec_count), 128'(11));
        chk("redir_eip", 128'(bus.dec_eip), 128'(32'h0000_1005));
        chk("redir_byte0", 128'(bus.dec_bytes[7:0]), 128'(bf(32'h0000_1005)));

        // Redirect while a line is outstanding; the stale line must be dropped.
        bus.ic_read_ready = 0;
        resp_delay = 3;
        bus.redirect = 1;
        bus.redirect_eip = 32'h0000_2000;
        tick();
        bus.redirect = 0;
        repeat (8) tick();
        chk("hold_req", 128'(bus.ic_read_valid), 128'(1));
        chk("hold_addr", 128'(bus.ic_addr), 128'(32'h0000_2000));
        bus.ic_read_ready = 1;
        tick();
        bus.ic_read_ready = 0;
        chk("in_wait", 128'(bus.ic_dp_ready), 128'(1));
        bus.redirect = 1;
        bus.redirect_eip = 32'h0000_3008;
        tick();
        bus.redirect = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("stale_dropped", 128'(bus.dec_valid), 128'(0));
        end
        chk("redir_req", 128'(bus.ic_read_valid), 128'(1));
        chk("redir_line", 128'(bus.ic_addr), 128'(32'h0000_3000));
        bus.ic_read_ready = 1;
        wait_valid("redir2_timeout", 20);
        chk("redir2_count", 128'(bus.dec_count), 128'(8));
        chk("redir2_eip", 128'(bus.dec_eip), 128'(32'h0000_3008));

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            bus.ic_read_ready = ($urandom_range(0, 3) != 0);
            resp_hold = ($urandom_range(0, 4) == 0);
            resp_delay = $urandom_range(0, 3);
            bus.dec_take = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 20))
                                                       : 5'($urandom_range(0, 8));
            bus.redirect = ($urandom_range(0, 49) == 0);
            bus.redirect_eip = ($urandom_range(0, 3) == 0)
                               ? 32'hFFFF_FFE0 + 32'($urandom_range(0, 31)) : $urandom;
            reset = ($urandom_range(0, 999) == 0);
            tick();
        end
        reset = 0;
        bus.redirect = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
